// File: rtl/k_and_s_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : k_and_s_pkg
//  Description : Shared types, ALU opcodes and branch evaluation for K&S core.
//  Revision    : 1.0 - initial release
// ============================================================================
package k_and_s_pkg;

    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_HALT   = 5'd15
    } decoded_instruction_type;

    typedef enum logic [2:0] {
        FETCH       = 3'd0,
        DECODE      = 3'd1,
        EXEC_LOAD   = 3'd2,
        EXEC_STORE  = 3'd3,
        EXEC_ALU    = 3'd4,
        EXEC_BRANCH = 3'd5,
        HALT        = 3'd6
    } ctrl_state_type;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Non-branch encodings report not-taken.
    function automatic logic branch_taken(
        input decoded_instruction_type instr,
        input logic                    zero,
        input logic                    neg,
        input logic                    uov
    );
        logic taken;
        taken = 1'b0;
        case (instr)
            I_BRANCH: taken = 1'b1;
            I_BZERO:  taken = zero;
            I_BNZERO: taken = ~zero;
            I_BNEG:   taken = neg;
            I_BNNEG:  taken = ~neg;
            I_BOV:    taken = uov;
            I_BNOV:   taken = ~uov;
            default:  taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Fetch/decode/execute Moore FSM driving the K&S datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_unit
    import k_and_s_pkg::*;
#(
    parameter int MEM_RD_WAIT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halted
);

    localparam int              CNT_W    = (MEM_RD_WAIT > 0) ? $clog2(MEM_RD_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_RD_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ctrl_state_type   state;
    ctrl_state_type   decode_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_done;

    assign wait_done = (wait_cnt == CNT_LAST);

    always_comb begin
        decode_next = FETCH;
        case (decoded_instruction)
            I_LOAD:  decode_next = EXEC_LOAD;
            I_STORE: decode_next = EXEC_STORE;
            I_ADD, I_SUB, I_AND, I_OR, I_MOVE:
                decode_next = EXEC_ALU;
            I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
                if (branch_taken(decoded_instruction, zero_op, neg_op, unsigned_overflow))
                    decode_next = EXEC_BRANCH;
            end
            I_HALT:  decode_next = HALT;
            default: decode_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (wait_done) begin
                        state    <= DECODE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
                DECODE: begin
                    state    <= decode_next;
                    wait_cnt <= '0;
                end
                EXEC_LOAD: begin
                    if (wait_done) begin
                        state    <= FETCH;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
                HALT: begin
                    state    <= HALT;
                    wait_cnt <= '0;
                end
                default: begin
                    state    <= FETCH;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Gated by rst_n so every strobe drops in the same cycle reset asserts.
    always_comb begin
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = ALU_ADD;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halted           = 1'b0;
        if (rst_n) begin
            c_sel = 1'b1;
            case (state)
                FETCH: begin
                    ir_enable = wait_done;
                end
                DECODE: begin
                    pc_enable = 1'b1;
                end
                EXEC_LOAD: begin
                    addr_sel         = 1'b1;
                    c_sel            = 1'b0;
                    write_reg_enable = wait_done;
                end
                EXEC_STORE: begin
                    addr_sel         = 1'b1;
                    ram_write_enable = 1'b1;
                end
                EXEC_ALU: begin
                    write_reg_enable = 1'b1;
                    flags_reg_enable = (decoded_instruction != I_MOVE);
                    case (decoded_instruction)
                        I_SUB:   operation = ALU_SUB;
                        I_AND:   operation = ALU_AND;
                        // MOVE relies on the datapath presenting a == b, so OR passes it through.
                        I_OR,
                        I_MOVE:  operation = ALU_OR;
                        default: operation = ALU_ADD;
                    endcase
                end
                EXEC_BRANCH: begin
                    pc_enable = 1'b1;
                    branch    = 1'b1;
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    c_sel = 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit
//  Description : Directed self-checking bench for control_unit (waits 1 and 3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;
    import k_and_s_pkg::*;

    logic                    clk   = 1'b0;
    logic                    rst_n = 1'b0;
    decoded_instruction_type instr = I_NOP;
    logic                    zero_op = 1'b0;
    logic                    neg_op  = 1'b0;
    logic                    uov     = 1'b0;

    logic       br1, pc1, ir1, as1, cs1, wr1, fl1, rw1, h1;
    logic [1:0] op1;
    logic       br3, pc3, ir3, as3, cs3, wr3, fl3, rw3, h3;
    logic [1:0] op3;

    // {branch, pc_en, ir_en, addr_sel, c_sel, op[1:0], wr_reg, flags, ram_we, halted}
    logic [10:0] obs1, obs3;
    assign obs1 = {br1, pc1, ir1, as1, cs1, op1, wr1, fl1, rw1, h1};
    assign obs3 = {br3, pc3, ir3, as3, cs3, op3, wr3, fl3, rw3, h3};

    localparam logic [10:0] E_RST = 11'h000;
    localparam logic [10:0] E_F   = 11'h040;
    localparam logic [10:0] E_FL  = 11'h140;
    localparam logic [10:0] E_DEC = 11'h240;
    localparam logic [10:0] E_ADD = 11'h04C;
    localparam logic [10:0] E_SUB = 11'h05C;
    localparam logic [10:0] E_AND = 11'h06C;
    localparam logic [10:0] E_OR  = 11'h07C;
    localparam logic [10:0] E_MOV = 11'h078;
    localparam logic [10:0] E_LD  = 11'h080;
    localparam logic [10:0] E_LDL = 11'h088;
    localparam logic [10:0] E_ST  = 11'h0C2;
    localparam logic [10:0] E_BR  = 11'h640;
    localparam logic [10:0] E_HLT = 11'h041;

    int checks = 0;
    int errors = 0;

    control_unit #(.MEM_RD_WAIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .decoded_instruction(instr),
        .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(uov),
        .branch(br1), .pc_enable(pc1), .ir_enable(ir1), .addr_sel(as1),
        .c_sel(cs1), .operation(op1), .write_reg_enable(wr1),
        .flags_reg_enable(fl1), .ram_write_enable(rw1), .halted(h1)
    );

    control_unit #(.MEM_RD_WAIT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .decoded_instruction(instr),
        .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(uov),
        .branch(br3), .pc_enable(pc3), .ir_enable(ir3), .addr_sel(as3),
        .c_sel(cs3), .operation(op3), .write_reg_enable(wr3),
        .flags_reg_enable(fl3), .ram_write_enable(rw3), .halted(h3)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        if (obs1 !== E_RST) begin errors++; $display("FAIL reset_w1: got %h want %h", obs1, E_RST); end
        checks++;
        if (obs3 !== E_RST) begin errors++; $display("FAIL reset_w3: got %h want %h", obs3, E_RST); end
        checks++;
        rst_n = 1'b1;
        #1;
        if (obs1 !== E_F) begin errors++; $display("FAIL reset_release_w1: got %h want %h", obs1, E_F); end
        checks++;
        if (obs3 !== E_F) begin errors++; $display("FAIL reset_release_w3: got %h want %h", obs3, E_F); end
        checks++;
    endtask

    task automatic test_alu();
        decoded_instruction_type ops [5];
        logic [10:0] res [5];
        logic [10:0] seq [$];
        ops = '{I_ADD, I_SUB, I_AND, I_OR, I_MOVE};
        res = '{E_ADD, E_SUB, E_AND, E_OR, E_MOV};
        for (int k = 0; k < 5; k++) begin
            instr = ops[k];
            seq = '{E_F, E_FL, E_DEC, res[k]};
            foreach (seq[i]) begin
                if (obs1 !== seq[i]) begin
                    errors++;
                    $display("FAIL alu_%0d cyc %0d: got %h want %h", k, i, obs1, seq[i]);
                end
                checks++;
                step();
            end
        end
    endtask

    task automatic test_store_nop_load();
        logic [10:0] seq [$];
        instr = I_STORE;
        seq = '{E_F, E_FL, E_DEC, E_ST};
        foreach (seq[i]) begin
            if (obs1 !== seq[i]) begin errors++; $display("FAIL store cyc %0d: got %h want %h", i, obs1, seq[i]); end
            checks++;
            step();
        end
        instr = I_NOP;
        seq = '{E_F, E_FL, E_DEC};
        foreach (seq[i]) begin
            if (obs1 !== seq[i]) begin errors++; $display("FAIL nop cyc %0d: got %h want %h", i, obs1, seq[i]); end
            checks++;
            step();
        end
        instr = I_LOAD;
        seq = '{E_F, E_FL, E_DEC, E_LD, E_LDL, E_F};
        foreach (seq[i]) begin
            if (obs1 !== seq[i]) begin errors++; $display("FAIL load_w1 cyc %0d: got %h want %h", i, obs1, seq[i]); end
            checks++;
            if (i < 5) step();
        end
    endtask

    task automatic test_branch();
        decoded_instruction_type bi [10];
        logic [2:0]  fl [10];
        logic        tk [10];
        logic [10:0] seq [$];
        decoded_instruction_type junk;
        logic [4:0] junk_code;
        junk_code = 5'h1F;
        junk = decoded_instruction_type'(junk_code);
        // flags as {zero, neg, uov}
        bi = '{I_BZERO, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_BRANCH, I_BNEG, junk};
        fl = '{3'b100,  3'b000,  3'b000,   3'b000, 3'b000,  3'b001, 3'b001, 3'b000,  3'b010, 3'b111};
        tk = '{1'b1,    1'b0,    1'b1,     1'b0,   1'b1,    1'b1,   1'b0,   1'b1,    1'b1,   1'b0};
        for (int k = 0; k < 10; k++) begin
            instr = bi[k];
            {zero_op, neg_op, uov} = fl[k];
            if (tk[k]) seq = '{E_F, E_FL, E_DEC, E_BR};
            else       seq = '{E_F, E_FL, E_DEC};
            foreach (seq[i]) begin
                if (obs1 !== seq[i]) begin
                    errors++;
                    $display("FAIL branch_%0d cyc %0d: got %h want %h", k, i, obs1, seq[i]);
                end
                checks++;
                step();
            end
        end
        {zero_op, neg_op, uov} = 3'b000;
    endtask

    task automatic test_halt();
        logic [10:0] seq [$];
        int bad;
        instr = I_HALT;
        seq = '{E_F, E_FL, E_DEC};
        foreach (seq[i]) begin
            if (obs1 !== seq[i]) begin errors++; $display("FAIL halt_entry cyc %0d: got %h want %h", i, obs1, seq[i]); end
            checks++;
            step();
        end
        instr = I_NOP;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            if (obs1 !== E_HLT) begin
                if (bad == 0) $display("FAIL halt_sticky cyc %0d: got %h want %h", c, obs1, E_HLT);
                bad++;
            end
            step();
        end
        if (bad != 0) errors++;
        checks++;
        rst_n = 1'b0;
        #1;
        if (obs1 !== E_RST) begin errors++; $display("FAIL halt_reset: got %h want %h", obs1, E_RST); end
        checks++;
        step();
        rst_n = 1'b1;
        #1;
        seq = '{E_F, E_FL, E_DEC, E_F};
        foreach (seq[i]) begin
            if (obs1 !== seq[i]) begin errors++; $display("FAIL halt_resume cyc %0d: got %h want %h", i, obs1, seq[i]); end
            checks++;
            if (i < 3) step();
        end
    endtask

    task automatic test_load_wait3();
        logic [10:0] seq [$];
        do_reset();
        instr = I_LOAD;
        seq = '{E_F, E_F, E_F, E_FL, E_DEC, E_LD, E_LD, E_LD, E_LDL, E_F};
        foreach (seq[i]) begin
            if (obs3 !== seq[i]) begin errors++; $display("FAIL load_w3 cyc %0d: got %h want %h", i, obs3, seq[i]); end
            checks++;
            if (i < 9) step();
        end
    endtask

    task automatic test_reset_mid_load();
        logic [10:0] seq [$];
        do_reset();
        instr = I_LOAD;
        seq = '{E_F, E_F, E_F, E_FL, E_DEC, E_LD, E_LD};
        foreach (seq[i]) begin
            if (obs3 !== seq[i]) begin errors++; $display("FAIL abort_pre cyc %0d: got %h want %h", i, obs3, seq[i]); end
            checks++;
            if (i < 6) step();
        end
        rst_n = 1'b0;
        #1;
        if (obs3 !== E_RST) begin errors++; $display("FAIL abort_same_cycle: got %h want %h", obs3, E_RST); end
        checks++;
        step();
        if (obs3 !== E_RST) begin errors++; $display("FAIL abort_held: got %h want %h", obs3, E_RST); end
        checks++;
        rst_n = 1'b1;
        instr = I_NOP;
        #1;
        seq = '{E_F, E_F, E_F, E_FL, E_DEC, E_F};
        foreach (seq[i]) begin
            if (obs3 !== seq[i]) begin errors++; $display("FAIL abort_post cyc %0d: got %h want %h", i, obs3, seq[i]); end
            checks++;
            if (i < 5) step();
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store_nop_load();
        test_branch();
        test_halt();
        test_load_wait3();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle Moore FSM that sequences the K&S datapath: fetch, decode, execute.
- Drives every datapath control strobe from the current state and from `decoded_instruction`.
- Evaluates conditional branches against the registered datapath flags.
- Also owns the RAM write strobe and a halted indicator for the top level.

Parameters:
- MEM_RD_WAIT, 1: number of extra cycles between presenting `ram_addr` and `data_in` becoming valid. Legal range 0..7; 0 means asynchronous-read RAM.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- decoded_instruction  in  decoded_instruction_type  instruction currently held in IR
- zero_op  in  1  registered zero flag
- neg_op  in  1  registered negative flag
- unsigned_overflow  in  1  registered unsigned-overflow flag
- branch  out  1  PC loads mem_addr instead of PC+1
- pc_enable  out  1  PC update strobe
- ir_enable  out  1  IR load strobe
- addr_sel  out  1  ram_addr source: 1 = mem_addr, 0 = PC
- c_sel  out  1  register write source: 1 = ALU, 0 = data_in
- operation  out  2  ALU op: 00 add, 01 sub, 10 and, 11 or
- write_reg_enable  out  1  register file write strobe
- flags_reg_enable  out  1  flag register update strobe
- ram_write_enable  out  1  RAM write strobe; data is data_out
- halted  out  1  core stopped on HALT

Behaviour:
- Clock is clk; reset is asynchronous, active-low, rst_n.
- Reset: state = FETCH, wait counter = 0. While rst_n is low, all outputs are 0, including operation = 00.
- Defaults in every state: all strobes 0, addr_sel 0, c_sel 1, operation 00.
- States:
  - FETCH, DECODE, EXEC_LOAD, EXEC_STORE, EXEC_ALU, EXEC_BRANCH, HALT.
- Wait counter:
  - Width $clog2(MEM_RD_WAIT+1), minimum 1.
  - Cleared on every state entry; increments while in FETCH or EXEC_LOAD.
- FETCH:
  - addr_sel 0 throughout. Lasts MEM_RD_WAIT+1 cycles.
  - ir_enable 1 only in the final cycle (counter == MEM_RD_WAIT).
  - Then go to DECODE.
- DECODE (1 cycle):
  - pc_enable 1, branch 0 (PC <= PC+1).
  - Next state by decoded_instruction:
    - LOAD -> EXEC_LOAD.
    - STORE -> EXEC_STORE.
    - ADD, SUB, AND, OR, MOVE -> EXEC_ALU.
    - Branch family: EXEC_BRANCH if taken, else FETCH.
    - HALT -> HALT.
    - NOP or any unlisted encoding -> FETCH.
- Branch taken conditions:
  - BRANCH always.
  - BZERO if zero_op; BNZERO if !zero_op.
  - BNEG if neg_op; BNNEG if !neg_op.
  - BOV if unsigned_overflow; BNOV if !unsigned_overflow.
  - Flags are sampled in the DECODE cycle.
- EXEC_LOAD:
  - addr_sel 1 and c_sel 0 throughout. Lasts MEM_RD_WAIT+1 cycles.
  - write_reg_enable 1 only in the final cycle. Then FETCH.
- EXEC_STORE (1 cycle): addr_sel 1, ram_write_enable 1. Then FETCH.
- EXEC_ALU (1 cycle):
  - c_sel 1, write_reg_enable 1.
  - operation: ADD 00, SUB 01, AND 10, OR 11, MOVE 11 (the datapath sets a = b, so OR passes the register through).
  - flags_reg_enable 1 for ADD/SUB/AND/OR; 0 for MOVE.
  - Then FETCH.
- EXEC_BRANCH (1 cycle): pc_enable 1, branch 1, overriding the DECODE increment. Then FETCH.
- HALT:
  - Sticky; halted 1; all strobes 0. Only rst_n exits.
- Instruction latency at MEM_RD_WAIT=1:
  - ALU, STORE, taken branch: 4 cycles.
  - NOP, not-taken branch: 3 cycles.
  - LOAD: 5 cycles.
- Reset mid-operation: immediate return to FETCH with no further strobes. A write pending in the aborted cycle is not issued.
- At most one of write_reg_enable and ram_write_enable is high in any cycle. ir_enable is never high outside FETCH.

Decomposition:
- k_and_s_pkg gains:
  - typedef enum ctrl_state_type { FETCH, DECODE, EXEC_LOAD, EXEC_STORE, EXEC_ALU, EXEC_BRANCH, HALT }.
  - ALU op constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR.
  - function branch_taken(decoded_instruction_type, zero, neg, uov).
- Reuses the existing decoded_instruction_type.
- No sub-module: the wait counter and output decode live inline.

Test Plan:
- Release reset at MEM_RD_WAIT=1 with IR decoding ADD -> ir_enable high in cycle 2; DECODE pc_enable=1; EXEC_ALU with operation=00, c_sel=1, write_reg_enable=1, flags_reg_enable=1; back in FETCH at cycle 5.
- LOAD at MEM_RD_WAIT=3 -> addr_sel=1 and c_sel=0 for 4 cycles; write_reg_enable only in the 4th; total 9 cycles.
- BZERO with zero_op=1 -> EXEC_BRANCH with branch=1, pc_enable=1. Repeat with zero_op=0 -> straight to FETCH, no branch strobe.
- MOVE -> operation=11, write_reg_enable=1, flags_reg_enable=0. STORE -> ram_write_enable=1, addr_sel=1, write_reg_enable=0.
- HALT -> halted=1 and all strobes 0 for 100 cycles; rst_n low for 1 cycle -> halted=0, FETCH resumes.
- rst_n asserted mid EXEC_LOAD (counter=1) -> outputs 0 in the same cycle; state FETCH after release; no write_reg_enable pulse.
